// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - oversampled SPI slave clocked entirely by CLK
// SCLK/SS/MOSI are synchronised, edge pulses are registered, and all shifting runs off those pulses.
module spi_slave_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  SCLK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic IDLE_LVL = (CPOL != 0);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_hist;
  logic                   r_ss_hist;
  logic                   r_mosi_d;
  logic                   r_lead;
  logic                   r_trail;
  logic                   r_ss_fall;
  logic                   r_ss_rise;

  state_t                 r_state;
  logic [CW-1:0]          r_bit_cnt;
  logic [DATA_WIDTH-1:0]  r_rx_sh;
  logic [DATA_WIDTH-1:0]  r_tx_sh;
  logic [DATA_WIDTH-1:0]  r_hold;
  logic                   r_hold_full;
  logic [DATA_WIDTH-1:0]  r_rx_data;
  logic                   r_rx_valid;
  logic                   r_underrun;
  logic                   r_miso;

  logic                   w_sclk;
  logic                   w_ss;
  logic                   w_mosi;
  logic                   w_active;
  logic                   w_sample;
  logic                   w_shift;
  logic                   w_load;
  logic                   w_capture;
  logic [DATA_WIDTH-1:0]  w_load_word;
  logic [DATA_WIDTH-1:0]  w_rx_next;
  logic [DATA_WIDTH-1:0]  w_tx_next;
  logic                   w_tx_out;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // r_mosi_d is taken alongside the history flops so the sampled bit matches the detected edge.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_hist <= 1'b0;
      r_ss_hist   <= 1'b1;
      r_mosi_d    <= 1'b0;
      r_lead      <= 1'b0;
      r_trail     <= 1'b0;
      r_ss_fall   <= 1'b0;
      r_ss_rise   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_hist <= w_sclk;
      r_ss_hist   <= w_ss;
      r_mosi_d    <= w_mosi;
      r_lead      <= (w_sclk != IDLE_LVL) && (r_sclk_hist == IDLE_LVL);
      r_trail     <= (w_sclk == IDLE_LVL) && (r_sclk_hist != IDLE_LVL);
      r_ss_fall   <= r_ss_hist && !w_ss;
      r_ss_rise   <= !r_ss_hist && w_ss;
    end
  end

  // An SS rise wins over any SCLK edge in the same cycle; edges seen in IDLE are ignored.
  assign w_active  = (r_state == ST_ACTIVE) && !r_ss_rise;
  assign w_sample  = w_active && ((CPHA != 0) ? r_trail : r_lead);
  assign w_shift   = w_active && ((CPHA != 0) ? r_lead : r_trail);
  assign w_load    = ((r_state == ST_IDLE) && r_ss_fall && (CPHA == 0)) ||
                     (w_shift && (r_bit_cnt == '0));
  assign w_capture = tx_valid && !r_hold_full;

  assign w_load_word = r_hold_full ? r_hold : '0;
  assign w_rx_next   = (LSB_FIRST != 0) ? {r_mosi_d, r_rx_sh[DATA_WIDTH-1:1]}
                                        : {r_rx_sh[DATA_WIDTH-2:0], r_mosi_d};
  assign w_tx_next   = w_load ? w_load_word
                              : ((LSB_FIRST != 0) ? (r_tx_sh >> 1) : (r_tx_sh << 1));
  assign w_tx_out    = (LSB_FIRST != 0) ? w_tx_next[0] : w_tx_next[DATA_WIDTH-1];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_miso      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= w_load && !r_hold_full;

      // A load in the same cycle as a capture consumes the old contents first.
      if (w_capture) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          r_miso    <= 1'b0;
          if (r_ss_fall) begin
            r_state <= ST_ACTIVE;
            r_rx_sh <= '0;
            if (w_load) begin
              r_tx_sh <= w_tx_next;
              r_miso  <= w_tx_out;
            end
          end
        end
        ST_ACTIVE: begin
          if (r_ss_rise) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_rx_sh   <= '0;
            r_tx_sh   <= '0;
            r_miso    <= 1'b0;
          end else begin
            if (w_sample) begin
              r_rx_sh <= w_rx_next;
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt  <= '0;
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
            if (w_shift) begin
              r_tx_sh <= w_tx_next;
              r_miso  <= w_tx_out;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MISO        = r_miso;
  assign tx_ready    = !r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;
  assign busy        = !r_ss_hist;

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - directed bench for spi_slave_param
// Instance 0 is 8-bit mode 0 MSB-first; instances 1..4 are 16-bit LSB-first modes 0..3.
module tb_spi_slave_param;

  localparam int H = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  sclk_p, ss_p, mosi_p, txv;
  wire  [4:0]  miso_w, txr, rxv, und, bsy;
  logic [15:0] txd [0:4];
  wire  [7:0]  rxd8;
  wire  [15:0] rxd16 [1:4];

  int vectors = 0;
  int errors  = 0;
  int rx_cnt [0:4];
  int und_cnt [0:4];
  int rdy_rise [0:4];
  logic [15:0] rx_log [0:4][0:3];
  logic [4:0]  txr_q;
  logic [15:0] m_tx [0:2];
  logic [15:0] m_rx [0:2];
  logic [15:0] m_feed [0:3];

  spi_slave_param u0 (
    .CLK(clk), .RESET_N(rst_n), .SCLK(sclk_p[0]), .SS(ss_p[0]), .MOSI(mosi_p[0]),
    .MISO(miso_w[0]), .tx_data(txd[0][7:0]), .tx_valid(txv[0]), .tx_ready(txr[0]),
    .rx_data(rxd8), .rx_valid(rxv[0]), .tx_underrun(und[0]), .busy(bsy[0])
  );

  generate
    for (genvar k = 1; k <= 4; k++) begin : g_mode
      spi_slave_param #(
        .DATA_WIDTH(16), .CPOL((k - 1) / 2), .CPHA((k - 1) % 2), .LSB_FIRST(1), .SYNC_STAGES(2)
      ) u (
        .CLK(clk), .RESET_N(rst_n), .SCLK(sclk_p[k]), .SS(ss_p[k]), .MOSI(mosi_p[k]),
        .MISO(miso_w[k]), .tx_data(txd[k]), .tx_valid(txv[k]), .tx_ready(txr[k]),
        .rx_data(rxd16[k]), .rx_valid(rxv[k]), .tx_underrun(und[k]), .busy(bsy[k])
      );
    end
  endgenerate

  function automatic logic [15:0] rx_of(input int i);
    case (i)
      0:       return {8'h00, rxd8};
      1:       return rxd16[1];
      2:       return rxd16[2];
      3:       return rxd16[3];
      default: return rxd16[4];
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rxv[i]) begin
        if (rx_cnt[i] < 4) rx_log[i][rx_cnt[i]] = rx_of(i);
        rx_cnt[i]++;
      end
      if (und[i]) und_cnt[i]++;
      if (txr[i] && !txr_q[i]) rdy_rise[i]++;
    end
    txr_q = txr;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 5; i++) begin
      rx_cnt[i] = 0;
      und_cnt[i] = 0;
      rdy_rise[i] = 0;
    end
  endtask

  // Master side of a frame: sends m_tx words, collects MISO into m_rx, leaves SS raised.
  task automatic spi_frame(input int inst, input int nbits);
    int w, lsb, cpha, wd, b, idx, nw, nb, nidx;
    logic pol;
    w    = (inst == 0) ? 8 : 16;
    lsb  = (inst == 0) ? 0 : 1;
    pol  = (inst == 0) ? 1'b0 : (((inst - 1) / 2) != 0);
    cpha = (inst == 0) ? 0 : (inst - 1) % 2;
    for (int j = 0; j < 3; j++) m_rx[j] = '0;
    ss_p[inst] = 1'b0;
    if (cpha == 0) mosi_p[inst] = m_tx[0][(lsb != 0) ? 0 : w - 1];
    wait_cyc(2 * H);
    for (int n = 0; n < nbits; n++) begin
      wd = n / w;
      b = n % w;
      idx = (lsb != 0) ? b : w - 1 - b;
      if (cpha == 0) begin
        m_rx[wd][idx] = miso_w[inst];
        sclk_p[inst] = ~pol;
        wait_cyc(H);
        sclk_p[inst] = pol;
        if (n + 1 < nbits) begin
          nw = (n + 1) / w;
          nb = (n + 1) % w;
          nidx = (lsb != 0) ? nb : w - 1 - nb;
          mosi_p[inst] = m_tx[nw][nidx];
        end
        wait_cyc(H);
      end else begin
        sclk_p[inst] = ~pol;
        mosi_p[inst] = m_tx[wd][idx];
        wait_cyc(H);
        m_rx[wd][idx] = miso_w[inst];
        sclk_p[inst] = pol;
        wait_cyc(H);
      end
    end
    ss_p[inst] = 1'b1;
    mosi_p[inst] = 1'b0;
  endtask

  task automatic feed(input int inst, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      txd[inst] = m_feed[k];
      txv[inst] = 1'b1;
      t = 0;
      while (!txr[inst] && t < 2000) begin
        @(negedge clk);
        t++;
      end
      vectors++;
      if (t >= 2000) begin
        errors++;
        $display("FAIL feed_timeout inst %0d word %0d: tx_ready stayed 0, required 1", inst, k);
      end
      @(negedge clk);
    end
    txv[inst] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(3);
    for (int i = 0; i < 5; i += 4) begin
      vectors++; if (miso_w[i] !== 1'b0) begin errors++; $display("FAIL reset_miso inst %0d: got %b need 0", i, miso_w[i]); end
      vectors++; if (txr[i] !== 1'b1) begin errors++; $display("FAIL reset_tx_ready inst %0d: got %b need 1", i, txr[i]); end
      vectors++; if (rx_of(i) !== 16'h0000) begin errors++; $display("FAIL reset_rx_data inst %0d: got %h need 0", i, rx_of(i)); end
      vectors++; if (rxv[i] !== 1'b0) begin errors++; $display("FAIL reset_rx_valid inst %0d: got %b need 0", i, rxv[i]); end
      vectors++; if (und[i] !== 1'b0) begin errors++; $display("FAIL reset_underrun inst %0d: got %b need 0", i, und[i]); end
      vectors++; if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d: got %b need 0", i, bsy[i]); end
    end
  endtask

  task automatic test_mode0_basic();
    m_feed[0] = 16'h00C1;
    feed(0, 1);
    clear_mon();
    m_tx[0] = 16'h00C1;
    m_feed[0] = 16'h00A5;
    fork
      spi_frame(0, 8);
      feed(0, 1);
    join
    wait_cyc(12);
    vectors++; if (rx_cnt[0] !== 1) begin errors++; $display("FAIL m0_rx_count: got %0d need 1", rx_cnt[0]); end
    vectors++; if (rx_of(0) !== 16'h00C1) begin errors++; $display("FAIL m0_rx_data: got %h need 00c1", rx_of(0)); end
    vectors++; if (m_rx[0] !== 16'h00C1) begin errors++; $display("FAIL m0_miso_word: got %h need 00c1", m_rx[0]); end
    vectors++; if (und_cnt[0] !== 0) begin errors++; $display("FAIL m0_underrun: got %0d pulses need 0", und_cnt[0]); end
  endtask

  task automatic test_modes16();
    for (int k = 1; k <= 4; k++) begin
      m_feed[0] = 16'h1234;
      feed(k, 1);
      clear_mon();
      m_tx[0] = 16'hA55A;
      spi_frame(k, 16);
      wait_cyc(12);
      vectors++; if (rx_cnt[k] !== 1) begin errors++; $display("FAIL mode%0d_rx_count: got %0d need 1", k - 1, rx_cnt[k]); end
      vectors++; if (rx_of(k) !== 16'hA55A) begin errors++; $display("FAIL mode%0d_rx_data: got %h need a55a", k - 1, rx_of(k)); end
      vectors++; if (m_rx[0] !== 16'h1234) begin errors++; $display("FAIL mode%0d_miso_word: got %h need 1234", k - 1, m_rx[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_rx [0:2];
    logic [15:0] exp_tx [0:2];
    exp_rx = '{16'h0001, 16'h0002, 16'h0003};
    exp_tx = '{16'h0011, 16'h0022, 16'h0033};
    for (int j = 0; j < 3; j++) begin
      m_tx[j] = exp_rx[j];
      m_feed[j] = exp_tx[j];
    end
    m_feed[3] = 16'h0000;
    clear_mon();
    fork
      spi_frame(0, 24);
      feed(0, 4);
    join
    wait_cyc(12);
    vectors++; if (rx_cnt[0] !== 3) begin errors++; $display("FAIL b2b_rx_count: got %0d need 3", rx_cnt[0]); end
    for (int j = 0; j < 3; j++) begin
      vectors++; if (rx_log[0][j] !== exp_rx[j]) begin errors++; $display("FAIL b2b_rx_word%0d: got %h need %h", j, rx_log[0][j], exp_rx[j]); end
      vectors++; if (m_rx[j] !== exp_tx[j]) begin errors++; $display("FAIL b2b_miso_word%0d: got %h need %h", j, m_rx[j], exp_tx[j]); end
    end
    vectors++; if (rdy_rise[0] !== 4) begin errors++; $display("FAIL b2b_tx_ready_rises: got %0d need 4", rdy_rise[0]); end
    vectors++; if (und_cnt[0] !== 0) begin errors++; $display("FAIL b2b_underrun: got %0d need 0", und_cnt[0]); end
  endtask

  task automatic test_underrun();
    clear_mon();
    m_tx[0] = 16'h0F0F;
    spi_frame(2, 16);
    wait_cyc(12);
    vectors++; if (und_cnt[2] !== 1) begin errors++; $display("FAIL ur_pulses: got %0d need 1", und_cnt[2]); end
    vectors++; if (m_rx[0] !== 16'h0000) begin errors++; $display("FAIL ur_miso_word: got %h need 0000", m_rx[0]); end
    vectors++; if (rx_cnt[2] !== 1) begin errors++; $display("FAIL ur_rx_count: got %0d need 1", rx_cnt[2]); end
    vectors++; if (rx_of(2) !== 16'h0F0F) begin errors++; $display("FAIL ur_rx_data: got %h need 0f0f", rx_of(2)); end
  endtask

  task automatic test_abort();
    clear_mon();
    m_tx[0] = 16'h00FF;
    spi_frame(0, 5);
    wait_cyc(2);
    vectors++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL abort_busy_early: got %b need 1", bsy[0]); end
    wait_cyc(1);
    vectors++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy_fall: got %b need 0", bsy[0]); end
    wait_cyc(12);
    vectors++; if (rx_cnt[0] !== 0) begin errors++; $display("FAIL abort_rx_count: got %0d need 0", rx_cnt[0]); end
    vectors++; if (rx_of(0) !== 16'h0003) begin errors++; $display("FAIL abort_rx_kept: got %h need 0003", rx_of(0)); end
    clear_mon();
    m_tx[0] = 16'h003C;
    m_feed[0] = 16'h0096;
    m_feed[1] = 16'h0000;
    fork
      spi_frame(0, 8);
      feed(0, 2);
    join
    wait_cyc(12);
    vectors++; if (rx_cnt[0] !== 1) begin errors++; $display("FAIL post_abort_rx_count: got %0d need 1", rx_cnt[0]); end
    vectors++; if (rx_of(0) !== 16'h003C) begin errors++; $display("FAIL post_abort_rx_data: got %h need 003c", rx_of(0)); end
    vectors++; if (m_rx[0] !== 16'h0096) begin errors++; $display("FAIL post_abort_miso_word: got %h need 0096", m_rx[0]); end
  endtask

  task automatic test_reset_mid_word();
    m_feed[0] = 16'h00F0;
    feed(0, 1);
    ss_p[0] = 1'b0;
    wait_cyc(8);
    m_feed[0] = 16'h005A;
    feed(0, 1);
    sclk_p[0] = 1'b1;
    wait_cyc(H);
    vectors++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b need 1", bsy[0]); end
    vectors++; if (miso_w[0] !== 1'b1) begin errors++; $display("FAIL mid_miso: got %b need 1", miso_w[0]); end
    vectors++; if (txr[0] !== 1'b0) begin errors++; $display("FAIL mid_tx_ready: got %b need 0", txr[0]); end
    rst_n = 1'b0;
    wait_cyc(1);
    vectors++; if (miso_w[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_miso: got %b need 0", miso_w[0]); end
    vectors++; if (txr[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_ready: got %b need 1", txr[0]); end
    vectors++; if (rx_of(0) !== 16'h0000) begin errors++; $display("FAIL rst_mid_rx_data: got %h need 0000", rx_of(0)); end
    vectors++; if (rxv[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_valid: got %b need 0", rxv[0]); end
    vectors++; if (und[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_underrun: got %b need 0", und[0]); end
    vectors++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b need 0", bsy[0]); end
    sclk_p[0] = 1'b0;
    ss_p[0] = 1'b1;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(8);
  endtask

  initial begin
    rst_n  = 1'b0;
    sclk_p = 5'b11000;
    ss_p   = 5'b11111;
    mosi_p = 5'b00000;
    txv    = 5'b00000;
    txr_q  = 5'b11111;
    for (int i = 0; i < 5; i++) txd[i] = '0;
    for (int i = 0; i < 3; i++) begin
      m_tx[i] = '0;
      m_rx[i] = '0;
    end
    for (int i = 0; i < 4; i++) m_feed[i] = '0;
    clear_mon();
    test_reset();
    test_mode0_basic();
    test_modes16();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
